// File: rtl/subtrator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : subtrator_pkg
// Brief   : Shared state encoding and default sizing for the serial subtractor.
// Rev     : 1.0 - initial release
// ============================================================================
package subtrator_pkg;

    localparam int c_WIDTH_DEFAULT = 8;
    localparam int c_DIGIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/subtrator_serial_sub_digit.sv
`default_nettype none
// ============================================================================
// Module  : sub_digit
// Brief   : Combinational DIGIT-bit ripple-borrow subtractor slice.
// Rev     : 1.0 - initial release
// ============================================================================
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] w_b;

    assign w_b[0] = bin;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            // Borrow when x < y + borrow_in at this bit position.
            assign d[i]     = x[i] ^ y[i] ^ w_b[i];
            assign w_b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b[i]);
        end
    endgenerate

    assign bo = w_b[DIGIT];

endmodule
`default_nettype wire

// File: rtl/subtrator_serial.sv
`default_nettype none
// ============================================================================
// Module  : subtrator_serial
// Brief   : Digit-serial unsigned subtractor, DIGIT bits per clock, valid/ready
//           handshakes on both sides. Define SUB_ABS_EN to return |a-b| with a
//           negative flag via an extra FIX cycle.
// Rev     : 1.0 - initial release
// ============================================================================
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int DIGIT = c_DIGIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             bout,
    output logic             neg
);

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("subtrator_serial: DIGIT must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [DIGIT-1:0]   w_d;
    logic               w_bo;
    logic [WIDTH-1:0]   w_s_next;

    // Operands shift right so the active slice always sits in the low bits.
    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .x   (r_a[DIGIT-1:0]),
        .y   (r_b[DIGIT-1:0]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    // Result fills from the top; after N slices the LSB slice reaches bit 0.
    assign w_s_next = (r_s >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

`ifdef SUB_ABS_EN
    logic r_neg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef SUB_ABS_EN
            r_neg       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_s        <= '0;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
`ifdef SUB_ABS_EN
                        r_neg      <= 1'b0;
`endif
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_s      <= w_s_next;
                    r_borrow <= w_bo;
                    if (r_cnt == c_LAST) begin
`ifdef SUB_ABS_EN
                        r_state     <= FIX;
`else
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIX: begin
`ifdef SUB_ABS_EN
                    if (r_borrow) begin
                        r_s <= ~r_s + WIDTH'(1);
                    end
                    r_neg <= r_borrow;
`endif
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign bout      = r_borrow;

`ifdef SUB_ABS_EN
    assign neg = r_neg;
`else
    assign neg = 1'b0;
`endif

endmodule
`default_nettype wire
